// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (sample ALU) -> RESP (hold response).
module alu_rr_scheduler #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [4:0]       req0_shamt,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [4:0]       req1_shamt,

   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_input1,
   output logic [WIDTH-1:0] alu_input2,
   output logic [4:0]       alu_shiftValue,

   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryFlag,
   input  logic             alu_zeroFlag,
   input  logic             alu_signFlag,

   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_carry,
   output logic             resp_zero,
   output logic             resp_sign,

   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0]       opcode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [4:0]       shamt;
   } op_t;

   state_t state;
   state_t state_nx;
   logic   last_grant;
   logic   grant_valid;
   logic   grant_id;
   logic   accept;
   op_t    op_sel;
   op_t    op_q;
   logic   id_q;

   // Round-robin: on a tie the requester not granted last wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latch is inferred.
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = ~last_grant;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b0;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end
   end

   always_comb begin
      if (grant_id) begin
         op_sel = '{opcode: req1_opcode, a: req1_a, b: req1_b, shamt: req1_shamt};
      end else begin
         op_sel = '{opcode: req0_opcode, a: req0_a, b: req0_b, shamt: req0_shamt};
      end
   end

   // Handshake outputs are gated by rst_n so they read 0 for the whole reset period.
   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b0;
      if (rst_n) begin
         busy = (state != IDLE);
         case (state)
            IDLE: begin
               req0_ready = grant_valid && !grant_id;
               req1_ready = grant_valid &&  grant_id;
               if (grant_valid) begin
                  accept   = 1'b1;
                  state_nx = EXEC;
               end
            end
            EXEC: state_nx = RESP;
            RESP: begin
               resp_valid = 1'b1;
               if (resp_ready) begin
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it is tested inside the clocked block.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q       <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         op_q       <= op_sel;
         id_q       <= grant_id;
         last_grant <= grant_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_id     <= 1'b0;
         resp_result <= '0;
         resp_carry  <= 1'b0;
         resp_zero   <= 1'b0;
         resp_sign   <= 1'b0;
      end else if (state == EXEC) begin
         resp_id     <= id_q;
         resp_result <= alu_result;
         resp_carry  <= alu_carryFlag;
         resp_zero   <= alu_zeroFlag;
         resp_sign   <= alu_signFlag;
      end
   end

   assign alu_opcode     = op_q.opcode;
   assign alu_input1     = op_q.a;
   assign alu_input2     = op_q.b;
   assign alu_shiftValue = op_q.shamt;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model and a behavioural ALU stub.
module tb_alu_rr_scheduler;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_opcode, req1_opcode;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]   req0_shamt, req1_shamt;
   logic [3:0]   alu_opcode;
   logic [W-1:0] alu_input1, alu_input2;
   logic [4:0]   alu_shiftValue;
   logic [W-1:0] alu_result;
   logic         alu_carryFlag, alu_zeroFlag, alu_signFlag;
   logic         resp_valid, resp_ready, resp_id;
   logic [W-1:0] resp_result;
   logic         resp_carry, resp_zero, resp_sign;
   logic         busy;

   alu_rr_scheduler #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
      .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_shiftValue(alu_shiftValue),
      .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
      .alu_zeroFlag(alu_zeroFlag), .alu_signFlag(alu_signFlag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_carry(resp_carry), .resp_zero(resp_zero),
      .resp_sign(resp_sign), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 SLL, 7 SRL, others return 0.
   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         s;
   } alu_t;

   function automatic alu_t alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [4:0] sh);
      alu_t       o;
      logic [W:0] t;
      o = '0;
      t = '0;
      case (op)
         4'd0: begin t = {1'b0, a} + {1'b0, b}; o.r = t[W-1:0]; o.c = t[W]; end
         4'd1: begin t = {1'b0, a} - {1'b0, b}; o.r = t[W-1:0]; o.c = t[W]; end
         4'd2: o.r = a & b;
         4'd3: o.r = a | b;
         4'd4: o.r = a ^ b;
         4'd5: o.r = ~(a & b);
         4'd6: o.r = a << sh;
         4'd7: o.r = a >> sh;
         default: o.r = '0;
      endcase
      o.z = (o.r == '0);
      o.s = o.r[W-1];
      return o;
   endfunction

   alu_t alu_o;
   always_comb alu_o = alu_ref(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
   assign alu_result    = alu_o.r;
   assign alu_carryFlag = alu_o.c;
   assign alu_zeroFlag  = alu_o.z;
   assign alu_signFlag  = alu_o.s;

   int checks = 0;
   int errors = 0;

   // Transaction model: one op in flight, response visible from the second cycle after accept.
   bit           inflight;
   int           age;
   bit           lg;
   logic         exp_id;
   logic [3:0]   exp_op;
   logic [W-1:0] exp_a, exp_b;
   logic [4:0]   exp_sh;
   alu_t         exp_res;

   int           obs_acc;
   bit           resp_done;
   bit           rv_now;
   logic         got_id;
   logic [W-1:0] got_result;
   logic         got_zero, got_sign;
   bit           reload0, reload1, rand_mode;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_payload(input int n);
      if (n == 0) begin
         req0_opcode = 4'($urandom_range(0, 15));
         req0_a      = {$urandom, $urandom};
         req0_b      = {$urandom, $urandom};
         req0_shamt  = 5'($urandom_range(0, 31));
      end else begin
         req1_opcode = 4'($urandom_range(0, 15));
         req1_a      = {$urandom, $urandom};
         req1_b      = {$urandom, $urandom};
         req1_shamt  = 5'($urandom_range(0, 31));
      end
   endtask

   // One clock cycle: check DUT against model at posedge+1, advance model, step, update stimulus.
   task automatic cycle();
      bit win_v;
      bit win;
      #1;
      obs_acc    = -1;
      resp_done  = 1'b0;
      got_result = 'x;
      got_id     = 1'bx;
      got_zero   = 1'bx;
      got_sign   = 1'bx;
      rv_now     = resp_valid;
      if (req0_ready && req0_valid) obs_acc = 0;
      else if (req1_ready && req1_valid) obs_acc = 1;
      if (!rst_n) begin
         chk("rst_ready0", req0_ready, 0);
         chk("rst_ready1", req1_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_resp_valid", resp_valid, 0);
         inflight = 1'b0;
         age      = 0;
         lg       = 1'b1;
      end else begin
         win_v = 1'b0;
         win   = 1'b0;
         if (!inflight) begin
            if (req0_valid && req1_valid) begin win_v = 1'b1; win = !lg; end
            else if (req0_valid) begin win_v = 1'b1; win = 1'b0; end
            else if (req1_valid) begin win_v = 1'b1; win = 1'b1; end
         end
         chk("ready0", req0_ready, win_v && !win);
         chk("ready1", req1_ready, win_v && win);
         chk("busy", busy, inflight);
         chk("resp_valid", resp_valid, inflight && age >= 1);
         if (inflight) begin
            chk("alu_opcode", alu_opcode, exp_op);
            chk("alu_input1", alu_input1, exp_a);
            chk("alu_input2", alu_input2, exp_b);
            chk("alu_shift", alu_shiftValue, exp_sh);
         end
         if (inflight && age >= 1) begin
            chk("resp_id", resp_id, exp_id);
            chk("resp_result", resp_result, exp_res.r);
            chk("resp_carry", resp_carry, exp_res.c);
            chk("resp_zero", resp_zero, exp_res.z);
            chk("resp_sign", resp_sign, exp_res.s);
         end
         if (win_v) begin
            inflight = 1'b1;
            age      = 0;
            lg       = win;
            exp_id   = win;
            exp_op   = win ? req1_opcode : req0_opcode;
            exp_a    = win ? req1_a : req0_a;
            exp_b    = win ? req1_b : req0_b;
            exp_sh   = win ? req1_shamt : req0_shamt;
            exp_res  = alu_ref(exp_op, exp_a, exp_b, exp_sh);
         end else if (inflight) begin
            if (age >= 1 && resp_ready) begin
               inflight   = 1'b0;
               resp_done  = 1'b1;
               got_id     = resp_id;
               got_result = resp_result;
               got_zero   = resp_zero;
               got_sign   = resp_sign;
            end else begin
               age++;
            end
         end
      end
      @(posedge clk);
      #1;
      if (obs_acc == 0) begin
         if (reload0) new_payload(0); else req0_valid = 1'b0;
      end
      if (obs_acc == 1) begin
         if (reload1) new_payload(1); else req1_valid = 1'b0;
      end
      if (rand_mode) begin
         if (!req0_valid) begin
            if ($urandom_range(0, 1) == 1) begin req0_valid = 1'b1; new_payload(0); end
         end else if ($urandom_range(0, 7) == 0) begin
            req0_valid = 1'b0;
         end
         if (!req1_valid) begin
            if ($urandom_range(0, 1) == 1) begin req1_valid = 1'b1; new_payload(1); end
         end else if ($urandom_range(0, 7) == 0) begin
            req1_valid = 1'b0;
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // who < 0 waits for any grant.
   task automatic wait_acc(input int who, input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         cycle();
         if ((who < 0 && obs_acc >= 0) || (who >= 0 && obs_acc == who)) hit = 1'b1;
      end
      if (!hit) begin
         checks++;
         errors++;
         $error("FAIL %s no grant to %0d within %0d cycles", tag, who, budget);
      end
   endtask

   task automatic wait_resp(input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         cycle();
         if (resp_done) hit = 1'b1;
      end
      if (!hit) begin
         checks++;
         errors++;
         $error("FAIL %s no response within %0d cycles", tag, budget);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      resp_ready = 1'b0;
      req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
      req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
      inflight = 1'b0; age = 0; lg = 1'b1;
      reload0 = 1'b0; reload1 = 1'b0; rand_mode = 1'b0;
      @(posedge clk);
      #1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      cycle(); cycle(); cycle();
      chk("rst_alu_opcode", alu_opcode, 0);
      chk("rst_alu_input1", alu_input1, 0);
      chk("rst_alu_input2", alu_input2, 0);
      chk("rst_resp_result", resp_result, 0);
      chk("rst_resp_id", resp_id, 0);

      // Tie after reset: req0 ADD first, then req1 SUB.
      req0_opcode = 4'd0; req0_a = 64'd5; req0_b = 64'd7;
      req1_opcode = 4'd1; req1_a = 64'd9; req1_b = 64'd4;
      resp_ready  = 1'b1;
      rst_n       = 1'b1;
      wait_acc(0, 4, "tie_acc0");
      wait_resp(6, "tie_resp0");
      chk("tie_id0", got_id, 0);
      chk("tie_result0", got_result, 12);
      chk("tie_zero0", got_zero, 0);
      wait_acc(1, 4, "tie_acc1");
      wait_resp(6, "tie_resp1");
      chk("tie_id1", got_id, 1);
      chk("tie_result1", got_result, 5);

      // Lone NAND of all-ones: zero result, response two cycles after handshake.
      req0_opcode = 4'd5; req0_a = '1; req0_b = '1; req0_valid = 1'b1;
      wait_acc(0, 4, "nand_acc");
      cycle();
      chk("nand_rv_exec", rv_now, 0);
      cycle();
      chk("nand_rv_resp", rv_now, 1);
      chk("nand_result", got_result, 0);
      chk("nand_zero", got_zero, 1);
      chk("nand_sign", got_sign, 0);

      // Backpressure: response held 10 cycles while req1 waits.
      resp_ready  = 1'b0;
      req0_opcode = 4'd0; req0_a = 64'd100; req0_b = 64'd23; req0_valid = 1'b1;
      wait_acc(0, 4, "bp_acc0");
      req1_opcode = 4'd2; req1_a = 64'hF0F0; req1_b = 64'hFF00; req1_valid = 1'b1;
      cycle();
      for (int i = 0; i < 10; i++) cycle();
      chk("bp_result", resp_result, 123);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_busy", busy, 1);
      resp_ready = 1'b1;
      cycle();
      chk("bp_resp_done", resp_done, 1);
      cycle();
      chk("bp_acc1", obs_acc, 1);
      wait_resp(6, "bp_resp1");
      chk("bp_result1", got_result, 64'hF000);

      // Both continuously valid after reset: grants alternate starting with req0.
      rst_n = 1'b0;
      cycle();
      rst_n   = 1'b1;
      reload0 = 1'b1;
      reload1 = 1'b1;
      new_payload(0); new_payload(1);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_acc(-1, 6, "rr_acc");
         chk("rr_grant", obs_acc, i % 2);
      end
      reload0 = 1'b0; reload1 = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_resp(6, "rr_drain");

      // Reset during EXEC aborts the op; next tie goes to req0.
      req0_opcode = 4'd6; req0_a = 64'd1; req0_b = '0; req0_shamt = 5'd4; req0_valid = 1'b1;
      wait_acc(0, 4, "abort_acc");
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("abort_no_resp", rv_now, 0);
      end
      chk("abort_busy", busy, 0);
      req0_opcode = 4'd0; req0_a = 64'd3; req0_b = 64'd4; req0_valid = 1'b1;
      req1_opcode = 4'd3; req1_a = 64'd8; req1_b = 64'd1; req1_valid = 1'b1;
      wait_acc(-1, 4, "abort_tie");
      chk("abort_tie_grant", obs_acc, 0);
      wait_resp(6, "abort_resp0");
      wait_acc(1, 4, "abort_acc1");
      wait_resp(6, "abort_resp1");
      chk("abort_result1", got_result, 9);

      // Out-of-range opcode is issued unchanged.
      req1_opcode = 4'd15; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      req1_valid  = 1'b1;
      wait_acc(1, 4, "op15_acc");
      cycle();
      chk("op15_alu_opcode", alu_opcode, 15);
      wait_resp(6, "op15_resp");
      chk("op15_id", got_id, 1);
      chk("op15_result", got_result, 0);

      // Random traffic with drops and backpressure.
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) cycle();
      rand_mode  = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      chk("final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
